// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//
// EX-stage controller sitting between the ID/EX register and an iterative
// radix-2 divider. It captures the operands of a DIV/DIVU instruction, runs
// the divider start/annul handshake, stalls the pipeline while the division
// is in flight and commits the result into the HI/LO registers. It also owns
// HI/LO, so MTHI/MTLO writes land here and MFHI/MFLO read hi_o/lo_o directly.
//
// Ports
//   clk, resetn      : clock, synchronous active-low reset
//   req_valid        : DIV/DIVU present in EX this cycle
//   req_signed       : 1 = DIV, 0 = DIVU
//   req_op1/req_op2  : dividend / divisor
//   flush            : flush of EX and younger stages
//   hi_we/lo_we      : MTHI / MTLO write strobes, data on hilo_wdata
//   stall_o          : hold EX and earlier stages
//   busy_o           : controller is not idle
//   div_opdata1_o/2_o: latched dividend / divisor to the divider
//   div_signed_o     : latched signed select to the divider
//   div_start_o      : divider start (held while the division runs)
//   div_annul_o      : divider cancel
//   div_result_i     : divider result, [63:32] remainder, [31:0] quotient
//   div_ready_i      : divider result valid
//   hi_o/lo_o        : HI and LO architectural registers
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic        stall_o,
  output logic        busy_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_signed_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // A zero drain length is treated as a single drain cycle so the divider
  // always sees at least one annul cycle after a flush.
  localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int unsigned CNT_W      = (DRAIN_LOAD > 0) ? $clog2(DRAIN_LOAD + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   drain_cnt_q;
  logic [31:0]        op1_q;
  logic [31:0]        op2_q;
  logic               signed_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic [31:0]        hi_d;
  logic [31:0]        lo_d;

  logic               is_idle;
  logic               is_busy;
  logic               is_drain;
  logic               accept;
  logic               commit;

  assign is_idle  = (state_q == ST_IDLE);
  assign is_busy  = (state_q == ST_BUSY);
  assign is_drain = (state_q == ST_DRAIN);

  // A request is only taken from IDLE; a same-cycle flush kills it.
  assign accept = is_idle && req_valid && !flush;

  // The result is only architecturally committed when the DIV itself is not
  // being flushed in the same cycle.
  assign commit = is_busy && div_ready_i && !flush;

  // HI/LO next value: a divider commit wins over same-cycle MTHI/MTLO.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = div_result_i[63:32];
      lo_d = div_result_i[31:0];
    end else begin
      if (hi_we) begin
        hi_d = hilo_wdata;
      end
      if (lo_we) begin
        lo_d = hilo_wdata;
      end
    end
  end

  // Controller FSM together with its operand and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      signed_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q  <= ST_BUSY;
            op1_q    <= req_op1;
            op2_q    <= req_op2;
            signed_q <= req_signed;
          end
        end

        ST_BUSY: begin
          // Flush takes priority over a same-cycle ready: the result is
          // dropped and the divider is annulled for the drain window.
          if (flush) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= CNT_W'(DRAIN_LOAD);
          end else if (div_ready_i) begin
            state_q <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            drain_cnt_q <= drain_cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Start drops in the ready cycle so the divider leaves its end state on
  // the commit edge instead of relaunching.
  assign div_start_o = is_busy && !div_ready_i && !flush;
  assign div_annul_o = (flush && is_busy) || is_drain;

  // In the commit cycle the stall is released so the DIV retires on the same
  // edge that HI/LO update.
  assign stall_o = (is_idle && req_valid && !flush) ||
                   (is_busy && !div_ready_i && !flush) ||
                   is_drain;

  assign busy_o        = !is_idle;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign div_signed_o  = signed_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//
// Bench for div_issue_ctrl. Contains a behavioural model of the iterative
// divider (samples start, ready 35 cycles later for a nonzero divisor or
// 3 cycles later for a zero divisor, cancelled by annul). Expected HI/LO
// values are computed from the stimulus operands and queued when a request
// is driven, then popped when the commit becomes visible.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_signed;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_signed_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_issue_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_signed   (req_signed),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .flush        (flush),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .hilo_wdata   (hilo_wdata),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .div_signed_o (div_signed_o),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference division: quotient truncates toward zero, remainder takes the
  // dividend sign, zero divisor yields zero for both.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Divider model
  logic        m_busy;
  logic [5:0]  m_cnt;
  logic [63:0] m_res;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_res  <= '0;
    end else if (m_busy) begin
      if (div_annul_o || m_cnt == 6'd0) begin
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 6'd1;
      end
    end else if (div_start_o && !div_annul_o) begin
      m_busy <= 1'b1;
      m_cnt  <= (div_opdata2_o == 32'd0) ? 6'd2 : 6'd34;
      m_res  <= ref_div(div_opdata1_o, div_opdata2_o, div_signed_o);
    end
  end

  assign div_ready_i  = m_busy && (m_cnt == 6'd0);
  assign div_result_i = div_ready_i ? m_res : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues a divide in the current cycle (cycle 0) and follows it through to
  // the cycle after commit. Returns at posedge+4 of that cycle.
  task automatic issue_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int exp_rdy, input logic collide);
    int   rc;
    int   stall_low;
    logic found;
    logic [63:0] e;
    req_valid  = 1'b1;
    req_op1    = a;
    req_op2    = b;
    req_signed = s;
    sb_q.push_back(ref_div(a, b, s));
    #1;
    chk("c0_stall", stall_o, 1);
    next_cycle();
    req_valid = 1'b0;
    #3;
    chk("c1_busy", busy_o, 1);
    chk("c1_start", div_start_o, 1);
    chk("c1_op1", div_opdata1_o, a);
    chk("c1_op2", div_opdata2_o, b);
    chk("c1_sgn", div_signed_o, s);
    found     = 1'b0;
    stall_low = 0;
    rc        = 0;
    for (int c = 2; c <= 60 && !found; c++) begin
      next_cycle();
      if (div_ready_i) begin
        found = 1'b1;
        rc    = c;
        if (collide) begin
          lo_we      = 1'b1;
          hilo_wdata = 32'hAAAA5555;
        end
      end
      #3;
      if (found) begin
        chk("rdy_cycle", rc, exp_rdy);
        chk("rdy_stall", stall_o, 0);
        chk("rdy_start", div_start_o, 0);
      end else if (!stall_o) begin
        stall_low++;
      end
    end
    chk("stall_hold", stall_low, 0);
    chk("rdy_seen", found, 1);
    next_cycle();
    lo_we = 1'b0;
    #3;
    if (found && sb_q.size() > 0) begin
      e      = sb_q.pop_front();
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      chk("commit_hi", hi_o, exp_hi);
      chk("commit_lo", lo_o, exp_lo);
      chk("commit_idle", busy_o, 0);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_op1    = '0;
    req_op2    = '0;
    flush      = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hilo_wdata = '0;

    // Reset state
    repeat (3) next_cycle();
    resetn = 1'b1;
    #3;
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_start", div_start_o, 0);
    chk("rst_annul", div_annul_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_op1", div_opdata1_o, 0);
    chk("rst_sgn", div_signed_o, 0);

    // Signed divide -7 / 2
    next_cycle();
    issue_div(32'hFFFFFFF9, 32'd2, 1'b1, 36, 1'b0);
    $display("txn signed div: hi=%h lo=%h", hi_o, lo_o);

    // Unsigned divide, immediately chained with a second request in the
    // commit-visible cycle
    next_cycle();
    issue_div(32'hFFFFFFF9, 32'd2, 1'b0, 36, 1'b0);
    $display("txn unsigned div: hi=%h lo=%h", hi_o, lo_o);
    issue_div(32'd1000, 32'd10, 1'b0, 36, 1'b0);
    $display("txn chained div: hi=%h lo=%h", hi_o, lo_o);

    // MTHI then MTLO from IDLE
    next_cycle();
    hi_we      = 1'b1;
    hilo_wdata = 32'h12345678;
    next_cycle();
    hi_we      = 1'b0;
    lo_we      = 1'b1;
    hilo_wdata = 32'h9ABCDEF0;
    #3;
    chk("mthi", hi_o, 32'h12345678);
    next_cycle();
    lo_we = 1'b0;
    #3;
    chk("mtlo", lo_o, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi_o, 32'h12345678);
    exp_hi = 32'h12345678;
    exp_lo = 32'h9ABCDEF0;
    $display("txn mthi/mtlo: hi=%h lo=%h", hi_o, lo_o);

    // Divide by zero
    next_cycle();
    issue_div(32'h1234, 32'd0, 1'b0, 4, 1'b0);
    $display("txn div by zero: hi=%h lo=%h", hi_o, lo_o);

    // Flush mid-divide, with an MTHI while BUSY
    next_cycle();
    req_valid  = 1'b1;
    req_op1    = 32'd50;
    req_op2    = 32'd5;
    req_signed = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      req_valid = 1'b0;
      hi_we     = (c == 5);
      if (c == 5) hilo_wdata = 32'h0F0F0F0F;
      if (c == 6) begin
        #3;
        chk("mthi_busy", hi_o, 32'h0F0F0F0F);
        exp_hi = 32'h0F0F0F0F;
      end
    end
    next_cycle();                 // cycle 10
    flush = 1'b1;
    #3;
    chk("fl10_annul", div_annul_o, 1);
    chk("fl10_start", div_start_o, 0);
    chk("fl10_stall", stall_o, 0);
    next_cycle();                 // cycle 11
    flush = 1'b0;
    #3;
    chk("fl11_annul", div_annul_o, 1);
    chk("fl11_stall", stall_o, 1);
    chk("fl11_busy", busy_o, 1);
    next_cycle();                 // cycle 12
    req_valid = 1'b1;
    req_op1   = 32'd9;
    req_op2   = 32'd3;
    #3;
    chk("fl12_annul", div_annul_o, 1);
    chk("fl12_stall", stall_o, 1);
    next_cycle();                 // cycle 13
    req_valid = 1'b0;
    #3;
    chk("fl13_busy", busy_o, 0);
    chk("fl13_annul", div_annul_o, 0);
    next_cycle();                 // cycle 14
    #3;
    chk("fl14_busy", busy_o, 0);
    chk("fl14_start", div_start_o, 0);
    chk("fl_hi", hi_o, exp_hi);
    chk("fl_lo", lo_o, exp_lo);
    $display("txn flushed div: hi=%h lo=%h", hi_o, lo_o);

    // Commit colliding with MTLO, then MTLO in the following cycle
    next_cycle();
    issue_div(32'd100, 32'd7, 1'b0, 36, 1'b1);
    lo_we      = 1'b1;
    hilo_wdata = 32'hAAAA5555;
    next_cycle();
    lo_we = 1'b0;
    #3;
    chk("mtlo_after", lo_o, 32'hAAAA5555);
    chk("mtlo_after_hi", hi_o, exp_hi);
    $display("txn collide div: hi=%h lo=%h", hi_o, lo_o);

    // Reset while BUSY
    next_cycle();
    req_valid  = 1'b1;
    req_op1    = 32'd77;
    req_op2    = 32'd7;
    req_signed = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      req_valid = 1'b0;
      if (c == 19) begin
        #3;
        chk("pre_rst_busy", busy_o, 1);
      end
    end
    resetn = 1'b0;                // cycle 20
    next_cycle();
    resetn = 1'b1;
    #3;
    chk("mrst_busy", busy_o, 0);
    chk("mrst_stall", stall_o, 0);
    chk("mrst_start", div_start_o, 0);
    chk("mrst_hi", hi_o, 0);
    chk("mrst_lo", lo_o, 0);
    $display("txn reset busy: hi=%h lo=%h", hi_o, lo_o);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
